// File: rtl/fas_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fas_chk_pkg
// Description : Shared types, constants and helpers for the multi-lane
//               golden-vector tolerance checker (stream_tol_checker).
//               - chk_state_e : checker FSM states
//               - fcnt_width  : width of a saturating counter reaching a limit
//               - tol_ok      : modular |got-exp| <= tol test over dw bits
// Revision    : 1.0 - initial release
// ============================================================================
package fas_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CMP   = 2'd2,
        ST_END   = 2'd3
    } chk_state_e;

    localparam int c_fail_limit_def = 48;

    // Bits needed for a counter that saturates at fail_limit.
    function automatic int fcnt_width(input int fail_limit);
        return $clog2(fail_limit + 1);
    endfunction

    localparam int c_fcnt_w_def = fcnt_width(c_fail_limit_def);

    // Accept when d = (got-exp) mod 2^dw lies within tol of zero on either
    // side of the wrap point. The upper test is written as (mask - d) < tol,
    // which is d >= 2^dw - tol without ever forming 2^dw.
    function automatic logic tol_ok(input logic [63:0] got,
                                    input logic [63:0] exp,
                                    input logic [63:0] tol,
                                    input int unsigned dw);
        logic [63:0] mask;
        logic [63:0] d;
        mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
        d    = (got - exp) & mask;
        return (d <= tol) || ((mask - d) < tol);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_tol_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_tol_checker_if
// Description : Bundle of all non-clock/reset signals of stream_tol_checker.
//               slave  : checker side (sinks the result stream, drives ROM
//                        address, error report and status)
//               master : environment side (producer, golden ROM, controller)
//   start      : one-cycle arm pulse
//   in_valid / in_ready / in_data : result vector handshake, lane 0 in LSBs
//   gold_addr / gold_rdata        : golden ROM, 1-cycle read latency
//   err_valid / err_index / err_got / err_exp : per-mismatch report
//   fail_cnt, busy, done, pass, abort, timeout : status
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_tol_checker_if #(
    parameter int DW    = 16,
    parameter int LANES = 16,
    parameter int AW    = 10,
    parameter int FCW   = 6
) ();
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_data;
    logic [AW-1:0]         gold_addr;
    logic [DW-1:0]         gold_rdata;
    logic                  err_valid;
    logic [AW-1:0]         err_index;
    logic [DW-1:0]         err_got;
    logic [DW-1:0]         err_exp;
    logic [FCW-1:0]        fail_cnt;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  abort;
    logic                  timeout;

    modport slave (
        input  start, in_valid, in_data, gold_rdata,
        output in_ready, gold_addr, err_valid, err_index, err_got, err_exp,
               fail_cnt, busy, done, pass, abort, timeout
    );

    modport master (
        output start, in_valid, in_data, gold_rdata,
        input  in_ready, gold_addr, err_valid, err_index, err_got, err_exp,
               fail_cnt, busy, done, pass, abort, timeout
    );
endinterface
`default_nettype wire

// File: rtl/chk_lane_cmp.sv
`default_nettype none
// ============================================================================
// Module      : chk_lane_cmp
// Description : One-lane tolerance comparator. The lane value and its word
//               index are captured in the address cycle so they line up with
//               the golden word returned one cycle later; the compare then
//               runs in that cycle and raises a one-cycle error report.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : a lane address is being issued this cycle
//   got_i, idx_i : lane value and word index for that address
//   exp_i        : golden ROM read data (belongs to last cycle's address)
//   err_valid_o  : mismatch pulse; err_index_o/err_got_o/err_exp_o are the
//                  mismatch details while it is high and zero otherwise
// Revision    : 1.0 - initial release
// ============================================================================
module chk_lane_cmp
    import fas_chk_pkg::*;
#(
    parameter int DW  = 16,
    parameter int AW  = 10,
    parameter int TOL = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [DW-1:0] got_i,
    input  logic [AW-1:0] idx_i,
    input  logic [DW-1:0] exp_i,
    output logic          err_valid_o,
    output logic [AW-1:0] err_index_o,
    output logic [DW-1:0] err_got_o,
    output logic [DW-1:0] err_exp_o
);
    logic          en_q;
    logic [DW-1:0] got_q;
    logic [AW-1:0] idx_q;
    logic          w_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            got_q <= '0;
            idx_q <= '0;
        end else begin
            en_q <= en_i;
            if (en_i) begin
                got_q <= got_i;
                idx_q <= idx_i;
            end
        end
    end

    assign w_ok        = tol_ok(64'(got_q), 64'(exp_i), 64'(TOL), DW);
    assign err_valid_o = en_q && !w_ok;
    // Details are gated so the report bus is quiet (and zero in reset)
    // outside a mismatch pulse.
    assign err_index_o = err_valid_o ? idx_q : '0;
    assign err_got_o   = err_valid_o ? got_q : '0;
    assign err_exp_o   = err_valid_o ? exp_i : '0;

endmodule
`default_nettype wire

// File: rtl/stream_tol_checker.sv
`default_nettype none
// ============================================================================
// Module      : stream_tol_checker
// Description : Golden-vector checker for LANES-wide DSP result streams.
//               Accepts a vector in ARMED, walks its lanes through the golden
//               ROM one per cycle (CMP), counts tolerance failures up to
//               FAIL_LIMIT and reports pass / fail / abort / timeout in END.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream_tol_checker_if.slave (handshake, ROM, error report,
//           status; see the interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_tol_checker
    import fas_chk_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LANES      = 16,
    parameter int TOL        = 3,
    parameter int NSAMP      = 1024,
    parameter int AW         = 10,
    parameter int FAIL_LIMIT = 48,
    parameter int TIMEOUT    = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_tol_checker_if.slave bus
);
    localparam int c_fcw = fcnt_width(FAIL_LIMIT);
    localparam int c_lw  = $clog2(LANES + 1);
    // Index runs past NSAMP by up to LANES-1 on a partial last vector.
    localparam int c_iw  = $clog2(NSAMP + LANES) + 1;
    localparam int c_tw  = $clog2(TIMEOUT + 1);

    chk_state_e            state_q, state_d;
    logic [c_iw-1:0]       idx_q, idx_d;
    logic [c_lw-1:0]       lane_q, lane_d;
    logic [LANES*DW-1:0]   data_q, data_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [c_tw-1:0]       tmo_q, tmo_d;
    logic [c_fcw-1:0]      fcnt_q, fcnt_d;
    logic                  abort_q, abort_d;
    logic                  tflag_q, tflag_d;

    logic [c_iw-1:0]       w_lane_idx;
    logic                  w_lane_live;
    logic                  w_issue;
    logic                  w_limit_hit;
    logic                  w_err_valid;
    logic [AW-1:0]         w_err_index;
    logic [DW-1:0]         w_err_got;
    logic [DW-1:0]         w_err_exp;

    // Lane lane_q is addressed in the current CMP cycle; lane_q == LANES is
    // the drain cycle in which only the last lane's compare happens.
    assign w_lane_idx  = idx_q + c_iw'(lane_q);
    assign w_lane_live = (lane_q < c_lw'(LANES)) && (w_lane_idx < c_iw'(NSAMP));
    // The mismatch being reported now is the one that reaches the limit.
    assign w_limit_hit = w_err_valid && (fcnt_q == c_fcw'(FAIL_LIMIT - 1));
    // Once the limit is hit no further lane enters the compare pipe.
    assign w_issue     = (state_q == ST_CMP) && w_lane_live && !w_limit_hit;

    chk_lane_cmp #(
        .DW  (DW),
        .AW  (AW),
        .TOL (TOL)
    ) u_lane_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (w_issue),
        .got_i       (data_q[DW-1:0]),
        .idx_i       (AW'(w_lane_idx)),
        .exp_i       (bus.gold_rdata),
        .err_valid_o (w_err_valid),
        .err_index_o (w_err_index),
        .err_got_o   (w_err_got),
        .err_exp_o   (w_err_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            tmo_q   <= '0;
            fcnt_q  <= '0;
            abort_q <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            fcnt_q  <= fcnt_d;
            abort_q <= abort_d;
            tflag_q <= tflag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        data_d  = data_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        fcnt_d  = fcnt_q;
        abort_d = abort_q;
        tflag_d = tflag_q;

        if (w_err_valid && (fcnt_q != c_fcw'(FAIL_LIMIT))) begin
            fcnt_d = fcnt_q + c_fcw'(1);
        end

        case (state_q)
            ST_IDLE, ST_END: begin
                if (bus.start) begin
                    state_d = ST_ARMED;
                    idx_d   = '0;
                    addr_d  = '0;
                    tmo_d   = '0;
                    fcnt_d  = '0;
                    abort_d = 1'b0;
                    tflag_d = 1'b0;
                end
            end

            ST_ARMED: begin
                if (bus.in_valid) begin
                    state_d = ST_CMP;
                    data_d  = bus.in_data;
                    lane_d  = '0;
                    addr_d  = AW'(idx_q);
                    tmo_d   = '0;
                end else if (tmo_q == c_tw'(TIMEOUT - 1)) begin
                    state_d = ST_END;
                    abort_d = 1'b1;
                    tflag_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + c_tw'(1);
                end
            end

            ST_CMP: begin
                lane_d = lane_q + c_lw'(1);
                if (w_issue) begin
                    // Next lane moves into the low word; the address stays
                    // on the last lane so it does not wander after the vector.
                    data_d = data_q >> DW;
                    if (lane_q != c_lw'(LANES - 1)) begin
                        addr_d = addr_q + AW'(1);
                    end
                end
                if (w_limit_hit) begin
                    state_d = ST_END;
                    abort_d = 1'b1;
                end else if (lane_q == c_lw'(LANES)) begin
                    idx_d = idx_q + c_iw'(LANES);
                    if ((idx_q + c_iw'(LANES)) >= c_iw'(NSAMP)) begin
                        state_d = ST_END;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_ARMED);
    assign bus.busy      = (state_q == ST_ARMED) || (state_q == ST_CMP);
    assign bus.done      = (state_q == ST_END);
    assign bus.pass      = (state_q == ST_END) && (fcnt_q == '0) && !abort_q;
    assign bus.abort     = abort_q;
    assign bus.timeout   = tflag_q;
    assign bus.fail_cnt  = fcnt_q;
    assign bus.gold_addr = addr_q;
    assign bus.err_valid = w_err_valid;
    assign bus.err_index = w_err_index;
    assign bus.err_got   = w_err_got;
    assign bus.err_exp   = w_err_exp;

endmodule
`default_nettype wire

// File: tb/tb_stream_tol_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stream_tol_checker
// Description : Self-checking bench for stream_tol_checker (4 lanes, 10
//               samples so the last vector is partial, FAIL_LIMIT 4,
//               TIMEOUT 20). Random ROM/result data is scored against a
//               word-by-word tolerance model; directed cases cover the
//               tolerance edge, wraparound, fail limit, timeout and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_tol_checker;
    localparam int DW         = 16;
    localparam int LANES      = 4;
    localparam int TOL        = 3;
    localparam int NSAMP      = 10;
    localparam int AW         = 4;
    localparam int FAIL_LIMIT = 4;
    localparam int TIMEOUT    = 20;
    localparam int FCW        = $clog2(FAIL_LIMIT + 1);
    localparam int NVEC       = (NSAMP + LANES - 1) / LANES;
    localparam int NWORD      = NVEC * LANES;

    typedef struct {
        int idx;
        int got;
        int gexp;
    } err_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_tol_checker_if #(.DW(DW), .LANES(LANES), .AW(AW), .FCW(FCW)) bus ();

    stream_tol_checker #(
        .DW(DW), .LANES(LANES), .TOL(TOL), .NSAMP(NSAMP), .AW(AW),
        .FAIL_LIMIT(FAIL_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] rom [0:(1<<AW)-1];
    logic [DW-1:0] dat [0:NWORD-1];
    err_t          obs_q[$];
    err_t          exp_q[$];
    int            n_checks = 0;
    int            n_errs   = 0;

    // Golden ROM with one cycle of read latency.
    always @(posedge clk) bus.gold_rdata <= rom[bus.gold_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errs++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    // |got-exp| taken on the 16-bit circle, computed with signed arithmetic.
    function automatic bit model_ok(input int g, input int e);
        int d;
        d = (g - e) % 65536;
        if (d < 0) d += 65536;
        return (d <= TOL) || (d >= 65536 - TOL);
    endfunction

    function automatic logic [LANES*DW-1:0] pack(input int v);
        logic [LANES*DW-1:0] p;
        p = '0;
        for (int l = 0; l < LANES; l++) p[l*DW +: DW] = dat[v*LANES + l];
        return p;
    endfunction

    // mode 0: mixed, 1: all within tolerance, 2: all outside tolerance
    task automatic gen(input int mode);
        int e, delta, r;
        for (int i = 0; i < (1 << AW); i++) begin
            rom[i] = DW'($urandom);
            if ($urandom_range(0, 5) == 0) rom[i] = DW'(65535 - int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < NWORD; i++) begin
            e = (i < NSAMP) ? int'(rom[i]) : int'($urandom_range(0, 65535));
            r = (mode == 1) ? 0 : (mode == 2) ? 9 : int'($urandom_range(0, 9));
            if (r <= 5)      delta = int'($urandom_range(0, 6)) - 3;
            else if (r <= 7) delta = ($urandom_range(0, 1) == 1) ? 4 : -4;
            else             delta = int'($urandom_range(4, 1000));
            if (r >= 8 && $urandom_range(0, 1) == 1) delta = -delta;
            dat[i] = DW'(e + delta);
        end
    endtask

    task automatic build_model(output int efc, output bit eab);
        exp_q.delete();
        efc = 0;
        eab = 1'b0;
        for (int i = 0; i < NSAMP; i++) begin
            if (!eab && !model_ok(int'(dat[i]), int'(rom[i]))) begin
                exp_q.push_back('{idx: i, got: int'(dat[i]), gexp: int'(rom[i])});
                efc++;
                if (efc == FAIL_LIMIT) eab = 1'b1;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ":in_ready"},  64'(bus.in_ready), 0);
        chk({tag, ":busy"},      64'(bus.busy), 0);
        chk({tag, ":done"},      64'(bus.done), 0);
        chk({tag, ":pass"},      64'(bus.pass), 0);
        chk({tag, ":abort"},     64'(bus.abort), 0);
        chk({tag, ":timeout"},   64'(bus.timeout), 0);
        chk({tag, ":fail_cnt"},  64'(bus.fail_cnt), 0);
        chk({tag, ":gold_addr"}, 64'(bus.gold_addr), 0);
        chk({tag, ":err_valid"}, 64'(bus.err_valid), 0);
        chk({tag, ":err_index"}, 64'(bus.err_index), 0);
        chk({tag, ":err_got"},   64'(bus.err_got), 0);
        chk({tag, ":err_exp"},   64'(bus.err_exp), 0);
    endtask

    // Arms the checker, streams all vectors with random valid gaps and
    // compares the captured error reports and final status with the model.
    task automatic run_check(input string tag, input bit poke_start);
        int efc, v, cyc, gap, late_err;
        bit eab, gap_on, acc, moved;
        logic [AW-1:0] addr_done;
        build_model(efc, eab);
        obs_q.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        v = 0; cyc = 0; gap = 0; gap_on = 1'b0; acc = 1'b0;
        while (!bus.done && cyc < 400) begin
            bus.start = 1'b0;
            if (acc) begin
                v++;
                bus.in_valid = 1'b0;
                gap_on = 1'b1;
                gap = 0;
                acc = 1'b0;
            end
            if (bus.err_valid)
                obs_q.push_back('{idx: int'(bus.err_index), got: int'(bus.err_got),
                                  gexp: int'(bus.err_exp)});
            if (gap_on) begin
                if (!bus.in_ready) gap++;
                else begin
                    chk({tag, ":ready_gap"}, 64'(gap), 64'(LANES + 1));
                    gap_on = 1'b0;
                end
            end
            // A start while busy must be ignored.
            if (poke_start && bus.busy && $urandom_range(0, 15) == 0) bus.start = 1'b1;
            // The producer may raise valid early and holds it until accepted.
            if (v < NVEC && !bus.in_valid && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = pack(v);
            end
            acc = bus.in_valid && bus.in_ready;
            @(negedge clk);
            cyc++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        if (cyc >= 400) chk({tag, ":done_within_bound"}, 0, 1);
        if (gap_on && !eab) chk({tag, ":done_latency"}, 64'(gap), 64'(LANES + 1));
        chk({tag, ":err_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, ":err_index"}, 64'(obs_q[i].idx),  64'(exp_q[i].idx));
            chk({tag, ":err_got"},   64'(obs_q[i].got),  64'(exp_q[i].got));
            chk({tag, ":err_exp"},   64'(obs_q[i].gexp), 64'(exp_q[i].gexp));
        end
        chk({tag, ":fail_cnt"}, 64'(bus.fail_cnt), 64'(efc));
        chk({tag, ":abort"},    64'(bus.abort), 64'(eab));
        chk({tag, ":pass"},     64'(bus.pass), 64'(efc == 0 && !eab));
        chk({tag, ":timeout"},  64'(bus.timeout), 0);
        chk({tag, ":busy"},     64'(bus.busy), 0);
        addr_done = bus.gold_addr;
        moved = 1'b0;
        late_err = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.gold_addr !== addr_done) moved = 1'b1;
            if (bus.err_valid) late_err++;
        end
        chk({tag, ":addr_hold"}, 64'(moved), 0);
        chk({tag, ":late_err"},  64'(late_err), 0);
        chk({tag, ":done_held"}, 64'(bus.done), 1);
    endtask

    initial begin
        int cnt, cyc;
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Everything within tolerance, including the partial last vector.
        gen(1);
        run_check("in_tol", 1'b0);

        // Tolerance edge: +3 accepted, +4 rejected.
        gen(1);
        for (int i = 0; i < NSAMP; i++) dat[i] = rom[i];
        rom[5] = 16'h0010;
        dat[5] = 16'h0013;
        run_check("tol_edge_ok", 1'b1);
        chk("tol_edge_ok:pass_const", 64'(bus.pass), 1);
        dat[5] = 16'h0014;
        run_check("tol_edge_bad", 1'b0);
        if (obs_q.size() == 0) chk("tol_edge_bad:err_seen", 0, 1);
        else begin
            chk("tol_edge_bad:idx_const", 64'(obs_q[0].idx), 5);
            chk("tol_edge_bad:got_const", 64'(obs_q[0].got), 64'h14);
            chk("tol_edge_bad:exp_const", 64'(obs_q[0].gexp), 64'h10);
        end
        chk("tol_edge_bad:fail_cnt_const", 64'(bus.fail_cnt), 1);
        chk("tol_edge_bad:pass_const", 64'(bus.pass), 0);

        // Wraparound: FFFE vs 0001 is d=3, vs 0002 is d=4.
        for (int i = 0; i < NSAMP; i++) dat[i] = rom[i];
        rom[2] = 16'hFFFE;
        dat[2] = 16'h0001;
        run_check("wrap_ok", 1'b0);
        chk("wrap_ok:pass_const", 64'(bus.pass), 1);
        dat[2] = 16'h0002;
        run_check("wrap_bad", 1'b0);
        if (obs_q.size() == 0) chk("wrap_bad:err_seen", 0, 1);
        else begin
            chk("wrap_bad:idx_const", 64'(obs_q[0].idx), 2);
            chk("wrap_bad:got_const", 64'(obs_q[0].got), 64'h0002);
            chk("wrap_bad:exp_const", 64'(obs_q[0].gexp), 64'hFFFE);
        end

        // Random mixtures.
        for (int r = 0; r < 12; r++) begin
            gen(0);
            run_check("rand", 1'b1);
        end

        // Every word wrong: abort at the fail limit.
        gen(2);
        run_check("limit", 1'b0);
        chk("limit:err_pulses", 64'(obs_q.size()), 64'(FAIL_LIMIT));
        chk("limit:abort_const", 64'(bus.abort), 1);
        chk("limit:timeout_const", 64'(bus.timeout), 0);
        chk("limit:pass_const", 64'(bus.pass), 0);
        chk("limit:fail_cnt_const", 64'(bus.fail_cnt), 64'(FAIL_LIMIT));

        // Timeout: armed with no traffic.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.in_ready) cnt++;
            @(negedge clk);
            cyc++;
        end
        chk("tmo:idle_cycles", 64'(cnt), 64'(TIMEOUT));
        chk("tmo:timeout", 64'(bus.timeout), 1);
        chk("tmo:abort", 64'(bus.abort), 1);
        chk("tmo:done", 64'(bus.done), 1);
        chk("tmo:pass", 64'(bus.pass), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("tmo_restart:done", 64'(bus.done), 0);
        chk("tmo_restart:abort", 64'(bus.abort), 0);
        chk("tmo_restart:timeout", 64'(bus.timeout), 0);
        chk("tmo_restart:busy", 64'(bus.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of the second vector.
        gen(1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int v = 0; v < 2; v++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pack(v);
            cyc = 0;
            while (!bus.in_ready && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("mid:ready_seen", 64'(bus.in_ready), 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        gen(1);
        dat[0] = DW'(int'(rom[0]) + 50);
        run_check("after_reset", 1'b0);
        if (obs_q.size() == 0) chk("after_reset:err_seen", 0, 1);
        else chk("after_reset:first_idx", 64'(obs_q[0].idx), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/stream_tol_checker.md
Name: stream_tol_checker

Overview:
- Synthesizable, parametrised golden-vector checker for multi-lane DSP output streams.
- It generalises the FIR/FFT tolerance check into one reusable block for on-chip self-test of FAS-class designs.
- It accepts LANES-wide result vectors over a valid/ready handshake and reads expected words from a 1-cycle-latency golden ROM.
- It compares lanes serially with a programmable modular tolerance, counts failures up to a limit, and reports pass, fail, abort and timeout.

Parameters:
- DW, 16, bits per lane word.
- LANES, 16, lanes per accepted vector (1 = FIR-style stream).
- TOL, 3, maximum allowed |got-exp| modulo 2^DW (0 = exact compare).
- NSAMP, 1024, total expected words before completion.
- AW, 10, golden address width (2^AW >= NSAMP).
- FAIL_LIMIT, 48, failure count that forces abort.
- TIMEOUT, 100000, idle cycles while armed before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: clear status and arm the checker.
- in_valid  in  1  result vector valid.
- in_ready  out  1  checker can accept a vector.
- in_data  in  LANES*DW  lane 0 in bits [DW-1:0].
- gold_addr  out  AW  golden ROM address.
- gold_rdata  in  DW  ROM data, valid the cycle after its address.
- err_valid  out  1  one-cycle pulse per mismatch.
- err_index  out  AW  word index of the mismatch.
- err_got  out  DW  DUT value of the mismatch.
- err_exp  out  DW  golden value of the mismatch.
- fail_cnt  out  $clog2(FAIL_LIMIT+1)  saturating mismatch count.
- busy  out  1  armed or comparing.
- done  out  1  level, held until the next start.
- pass  out  1  valid when done: 1 only if fail_cnt==0 and not aborted.
- abort  out  1  fail limit reached or timeout.
- timeout  out  1  abort was caused by timeout.

Behaviour:
- Reset: all outputs 0, gold_addr 0, state IDLE, word index 0, timeout counter 0.
- States:
  - IDLE: in_ready=0. start -> ARMED; clears fail_cnt, done, pass, abort, timeout and the index.
  - ARMED: in_ready=1.
    - in_valid&in_ready at cycle T: latch in_data -> CMP, lane=0.
    - Otherwise the timeout counter increments. At TIMEOUT -> END with abort=1, timeout=1.
    - The counter clears on every accepted vector.
  - CMP (lane pipeline):
    - Cycle T+1+l: gold_addr = index+l.
    - Cycle T+2+l: compare lane l against gold_rdata.
    - After lane LANES-1 is compared (cycle T+LANES+1), advance index by LANES.
    - If index >= NSAMP -> END, else -> ARMED (in_ready high at T+LANES+2).
  - END: done=1, busy=0. pass=(fail_cnt==0)&&!abort. start -> ARMED.
- Compare rule: d = (got - exp) mod 2^DW. Pass iff d <= TOL or d >= 2^DW - TOL. Unsigned wraparound is intended.
- Mismatch: err_valid pulses in the compare cycle with index+l, got and exp. fail_cnt increments.
  - When fail_cnt reaches FAIL_LIMIT: abort=1, remaining lanes are skipped, -> END next cycle.
  - fail_cnt never exceeds FAIL_LIMIT.
- NSAMP not a multiple of LANES: lanes whose index >= NSAMP are not compared and raise no error.
- start while busy is ignored. in_valid outside ARMED is ignored; the producer holds the vector until ready.
- Asynchronous reset mid-operation returns to the reset state immediately. No partial results persist.

Decomposition:
- Shared package fas_chk_pkg:
  - State enum (IDLE, ARMED, CMP, END).
  - Function tol_ok(got, exp, tol) with modular width DW.
  - Localparam for the fail_cnt width.
- One sub-module, chk_lane_cmp: registered tolerance comparator plus error-capture register, so the top holds only the FSM, counters and address generation.

Test Plan:
- LANES=1, TOL=0, NSAMP=8, ROM=0..7, DUT sends 0..7:
  - Required: no err_valid.
  - Required: done=1, pass=1 one cycle after the 8th compare.
  - Required: in_ready low exactly 2 cycles per word.
- LANES=16, TOL=3, ROM word 5 = 16'h0010, DUT lane5 = 16'h0013 then 16'h0014 in a rerun:
  - Required on the first run: pass.
  - Required on the rerun: err_valid with err_index=5, err_got=16'h0014, err_exp=16'h0010, fail_cnt=1, pass=0.
- Wraparound, TOL=3: exp=16'hFFFE, got=16'h0001 -> accepted (d=3). Same exp with got=16'h0002 -> mismatch.
- FAIL_LIMIT=4, all DUT words wrong:
  - Required: exactly 4 err_valid pulses.
  - Required: abort=1, done=1, pass=0, timeout=0, fail_cnt=4.
  - Required: no further gold_addr changes.
- TIMEOUT=20, start with no in_valid:
  - Required: timeout=1, abort=1, done=1 on the 20th idle cycle.
  - A subsequent start clears all of these flags.
- Reset asserted during lane 7 of a vector:
  - Required: all outputs 0 immediately.
  - Required: after release and start, checking restarts at index 0.
